mul_norm_round: RTL and testbench

Downstream stage of the 24x24 booth mantissa multiplier. Consumes the raw 48-bit mantissa product, the pre-summed exponent, the result sign and any operand exception, and produces the final IEEE-754 single-precision product. It normalizes, rounds to nearest-even, renormalizes and checks exponent range. It sits between the multiplier and the Mul_cntrl result register, with the same REQ/ACK four-phase handshake.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/rne_rounder.sv | 24 ++
 rtl/mul_norm_round.sv | 124 ++++++++++++
 tb/tb_mul_norm_round.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and constants for the FP multiplier result path
package fpu_pkg;

  typedef enum logic [2:0] {
    EXC_NONE  = 3'b000,
    EXC_ZERO  = 3'b001,
    EXC_UNDER = 3'b010,
    EXC_NAN   = 3'b011,
    EXC_INF   = 3'b100
  } exc_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NORM  = 3'd1,
    ST_ROUND = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } norm_state_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam int          EXP_MAX = 255;
  localparam int          BIAS    = 127;

endpackage

// File: rtl/rne_rounder.sv
// rtl/rne_rounder.sv - round-to-nearest-even increment of a normalized mantissa
module rne_rounder #(
  parameter int W = 24
) (
  input  logic [W-1:0] mant,
  input  logic         g,
  input  logic         r,
  input  logic         s,
  output logic [W-1:0] mant_rnd,
  output logic         carry
);

  logic         inc;
  logic [W:0]   sum;

  always_comb begin
    inc      = g & (r | s | mant[0]);
    sum      = {1'b0, mant} + {{W{1'b0}}, inc};
    carry    = sum[W];
    // an all-ones mantissa rolls over to exactly 1.0; exponent bump is the caller's job
    mant_rnd = carry ? {1'b1, {(W-1){1'b0}}} : sum[W-1:0];
  end

endmodule

// File: rtl/mul_norm_round.sv
// rtl/mul_norm_round.sv - normalize, round and range-check a raw mantissa product
module mul_norm_round
  import fpu_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int BIAS   = fpu_pkg::BIAS
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       REQ,
  input  logic [2*(MANT_W+1)-1:0]    PROD,
  input  logic [EXP_W+1:0]           EXP_SUM,
  input  logic                       SIGN,
  input  logic [2:0]                 IN_EXC,
  output logic [EXP_W+MANT_W:0]      RESULT,
  output logic [2:0]                 EXC,
  output logic                       ACK
);

  localparam int MW    = MANT_W + 1;
  localparam int PW    = 2 * MW;
  localparam int XW    = EXP_W + 4;
  localparam int RES_W = 1 + EXP_W + MANT_W;
  localparam logic signed [XW-1:0] EXP_TOP  = XW'(2 * BIAS + 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  norm_state_t            state;
  logic [PW-1:0]          prod_q;
  logic signed [XW-1:0]   exp_q;
  logic                   sign_q;
  logic [2:0]             in_exc_q;
  logic [MW-1:0]          mant_q;
  logic                   g_q;
  logic                   r_q;
  logic                   s_q;

  logic [MW-1:0]          rnd_mant;
  logic                   rnd_carry;

  rne_rounder #(.W(MW)) u_rne_rounder (
    .mant     (mant_q),
    .g        (g_q),
    .r        (r_q),
    .s        (s_q),
    .mant_rnd (rnd_mant),
    .carry    (rnd_carry)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      RESULT <= '0;
      EXC    <= EXC_NONE;
      ACK    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            prod_q   <= PROD;
            exp_q    <= XW'(signed'(EXP_SUM));
            sign_q   <= SIGN;
            in_exc_q <= IN_EXC;
            state    <= ST_NORM;
          end
        end
        ST_NORM: begin
          // product lies in [1,4): at most one position of left-justification
          if (prod_q[PW-1]) begin
            mant_q <= prod_q[PW-1 -: MW];
            g_q    <= prod_q[PW-1-MW];
            r_q    <= prod_q[PW-2-MW];
            s_q    <= |prod_q[PW-3-MW:0];
            exp_q  <= exp_q + XW'(1);
          end else begin
            mant_q <= prod_q[PW-2 -: MW];
            g_q    <= prod_q[PW-2-MW];
            r_q    <= prod_q[PW-3-MW];
            s_q    <= |prod_q[PW-4-MW:0];
          end
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          mant_q <= rnd_mant;
          exp_q  <= exp_q + XW'(rnd_carry);
          state  <= ST_CHECK;
        end
        ST_CHECK: begin
          if (in_exc_q == EXC_NAN) begin
            RESULT <= RES_W'(QNAN);
            EXC    <= EXC_NAN;
          end else if (in_exc_q == EXC_INF) begin
            RESULT <= {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            EXC    <= EXC_INF;
          end else if (in_exc_q == EXC_ZERO || prod_q == '0) begin
            RESULT <= {sign_q, {(EXP_W+MANT_W){1'b0}}};
            EXC    <= EXC_ZERO;
          end else if (exp_q >= EXP_TOP) begin
            RESULT <= {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            EXC    <= EXC_INF;
          end else if (exp_q <= EXP_ZERO) begin
            RESULT <= {sign_q, {(EXP_W+MANT_W){1'b0}}};
            EXC    <= EXC_UNDER;
          end else begin
            RESULT <= {sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-1:0]};
            EXC    <= EXC_NONE;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          // first DONE cycle always raises ACK, so an early REQ drop still sees a pulse
          if (!ACK) begin
            ACK <= 1'b1;
          end else if (!REQ) begin
            ACK   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_norm_round.sv
// tb/tb_mul_norm_round.sv - randomized self-checking bench with arithmetic reference model
module tb_mul_norm_round;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ;
  logic [47:0] PROD;
  logic [9:0]  EXP_SUM;
  logic        SIGN;
  logic [2:0]  IN_EXC;
  logic [31:0] RESULT;
  logic [2:0]  EXC;
  logic        ACK;

  mul_norm_round dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .PROD    (PROD),
    .EXP_SUM (EXP_SUM),
    .SIGN    (SIGN),
    .IN_EXC  (IN_EXC),
    .RESULT  (RESULT),
    .EXC     (EXC),
    .ACK     (ACK)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  exc;
    int          cap;
  } exp_t;

  typedef struct {
    logic [47:0] p;
    logic [9:0]  es;
    logic        s;
    logic [2:0]  ie;
    logic [31:0] r;
    logic [2:0]  x;
  } vec_t;

  exp_t q[$];
  exp_t cur;
  logic ack_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Value-level reference: scale to 24 significant bits, round by remainder vs half-ulp.
  function automatic logic [34:0] model(input logic [47:0] p, input logic [9:0] es,
                                        input logic s, input logic [2:0] ie);
    longint kept, rem, half, pv;
    int     sh, e;
    logic [31:0] ev;
    if (ie == 3'd3) return {3'd3, 32'h7FC0_0000};
    if (ie == 3'd4) return {3'd4, s, 8'hFF, 23'h0};
    if (ie == 3'd1 || p == 48'h0) return {3'd1, s, 31'h0};
    pv   = longint'(p);
    sh   = p[47] ? 24 : 23;
    e    = int'(signed'(es)) + (p[47] ? 1 : 0);
    kept = pv >> sh;
    rem  = pv % (longint'(1) << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && (kept % 2) == 1)) kept = kept + 1;
    if (kept == (longint'(1) << 24)) begin
      kept = kept / 2;
      e    = e + 1;
    end
    if (e >= 255) return {3'd4, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'd2, s, 31'h0};
    ev = 32'(e);
    return {3'd0, s, ev[7:0], kept[22:0]};
  endfunction

  // Compare process: every ACK-high cycle must show the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!RST) begin
      if (ACK && !ack_prev) begin
        if (q.size() == 0) begin
          check("unexpected_ack", 64'(q.size()), 64'd1);
        end else begin
          cur = q.pop_front();
          check("result", {29'h0, EXC, RESULT}, {29'h0, cur.exc, cur.res});
          check("latency", 64'(cyc - cur.cap), 64'd4);
        end
      end else if (ACK) begin
        check("result_stable", {29'h0, EXC, RESULT}, {29'h0, cur.exc, cur.res});
      end
    end
    ack_prev = ACK;
  end

  task automatic run_txn(input logic [47:0] p, input logic [9:0] es, input logic s,
                         input logic [2:0] ie, input bit early, input int extra);
    exp_t        e;
    logic [34:0] m;
    int          n;
    m = model(p, es, s, ie);
    @(negedge CLK);
    PROD = p; EXP_SUM = es; SIGN = s; IN_EXC = ie; REQ = 1'b1;
    e.res = m[31:0]; e.exc = m[34:32]; e.cap = cyc + 1;
    q.push_back(e);
    if (early) begin
      @(negedge CLK);
      REQ = 1'b0;
    end
    n = 0;
    while (!ACK && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("ack_seen", 64'(ACK), 64'd1);
    if (early) begin
      @(negedge CLK);
      check("pulse_width", 64'(ACK), 64'd0);
    end else begin
      for (int i = 0; i < extra; i++) begin
        @(negedge CLK);
        check("ack_hold", 64'(ACK), 64'd1);
      end
      REQ = 1'b0;
      @(negedge CLK);
      check("ack_drop", 64'(ACK), 64'd0);
    end
    check("result_held", {29'h0, EXC, RESULT}, {29'h0, e.exc, e.res});
  endtask

  vec_t        dv[$];
  logic [34:0] m;
  logic [63:0] rnd;
  logic [47:0] rp;
  int          sel, ack_seen;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; REQ = 1'b0; PROD = '0; EXP_SUM = '0; SIGN = 1'b0; IN_EXC = '0;
    repeat (3) @(negedge CLK);
    check("reset_result", 64'(RESULT), 64'h0);
    check("reset_exc", 64'(EXC), 64'h0);
    check("reset_ack", 64'(ACK), 64'h0);
    RST = 1'b0;

    dv.push_back('{48'h7900_0000_0000, 10'd130, 1'b0, 3'd0, 32'h4172_0000, 3'd0});
    dv.push_back('{48'h7900_0000_0000, 10'd130, 1'b1, 3'd0, 32'hC172_0000, 3'd0});
    dv.push_back('{48'h9000_0000_0000, 10'd127, 1'b0, 3'd0, 32'h4010_0000, 3'd0});
    dv.push_back('{48'h7FFF_FFC0_0000, 10'd127, 1'b0, 3'd0, 32'h4000_0000, 3'd0});
    dv.push_back('{48'h4000_0040_0000, 10'd127, 1'b0, 3'd0, 32'h3F80_0000, 3'd0});
    dv.push_back('{48'h4000_0040_0001, 10'd127, 1'b0, 3'd0, 32'h3F80_0001, 3'd0});
    dv.push_back('{48'h4000_0000_0000, 10'd255, 1'b0, 3'd0, 32'h7F80_0000, 3'd4});
    dv.push_back('{48'h4000_0000_0000, 10'd254, 1'b0, 3'd0, 32'h7F00_0000, 3'd0});
    dv.push_back('{48'h7FFF_FFC0_0000, 10'd254, 1'b0, 3'd0, 32'h7F80_0000, 3'd4});
    dv.push_back('{48'h4000_0000_0000, 10'd0,   1'b1, 3'd0, 32'h8000_0000, 3'd2});
    dv.push_back('{48'h4000_0000_0000, 10'd1,   1'b0, 3'd0, 32'h0080_0000, 3'd0});
    dv.push_back('{48'h0000_0000_0000, 10'd127, 1'b0, 3'd0, 32'h0000_0000, 3'd1});
    dv.push_back('{48'h1234_5678_9ABC, 10'd127, 1'b0, 3'd3, 32'h7FC0_0000, 3'd3});
    dv.push_back('{48'h5555_0000_0000, 10'd127, 1'b1, 3'd4, 32'hFF80_0000, 3'd4});

    foreach (dv[i]) begin
      m = model(dv[i].p, dv[i].es, dv[i].s, dv[i].ie);
      check($sformatf("model_vec%0d", i), {29'h0, m}, {29'h0, dv[i].x, dv[i].r});
      run_txn(dv[i].p, dv[i].es, dv[i].s, dv[i].ie, (i == 2), (i == 0) ? 3 : 0);
    end

    // Reset while the operation sits in ROUND: must abort without ACK.
    @(negedge CLK);
    PROD = 48'h7900_0000_0000; EXP_SUM = 10'd130; SIGN = 1'b1; IN_EXC = 3'd0; REQ = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_result", 64'(RESULT), 64'h0);
    check("abort_exc", 64'(EXC), 64'h0);
    check("abort_ack", 64'(ACK), 64'h0);
    RST = 1'b0; REQ = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (ACK) ack_seen++;
    end
    check("no_ack_after_abort", 64'(ack_seen), 64'd0);

    for (int t = 0; t < 150; t++) begin
      rnd = {$urandom(), $urandom()};
      rp  = rnd[47:0];
      if (rp[47:46] == 2'b00) rp[46] = 1'b1;
      if ($urandom_range(0, 3) == 0) rp[20:0] = '0;
      if ($urandom_range(0, 15) == 0) rp = '0;
      sel = $urandom_range(0, 9);
      run_txn(rp, 10'($urandom_range(0, 340) - 40), 1'($urandom_range(0, 1)),
              (sel == 7) ? 3'd1 : (sel == 8) ? 3'd3 : (sel == 9) ? 3'd4 : 3'd0,
              ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    repeat (3) @(negedge CLK);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
